// File: rtl/cdr_ctrl_pkg.sv
// Shared definitions for the CDR lock controller: state encoding, parameter defaults
// and a small width helper.
package cdr_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_SETTLE = 2'd0,
        ST_ACQ    = 2'd1,
        ST_TRACK  = 2'd2,
        ST_LOCK   = 2'd3
    } cdr_state_e;

    localparam int SETTLE_CYC_DEF = 16;
    localparam int WIN_DEF        = 64;
    localparam int FAST_STEP_DEF  = 2;
    localparam int ACQ_TH_DEF     = 8;
    localparam int LOCK_TH_DEF    = 4;
    localparam int UNLOCK_TH_DEF  = 16;

    localparam logic [5:0] VS_RST = 6'd8;

    // Counter width that still holds n-1, never zero bits wide.
    function automatic int cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cdr_win_acc.sv
// Vote window accumulator: counts accepted votes, tracks signed up-minus-down net,
// and flags the WIN-th vote together with |net| including that vote.
module cdr_win_acc
    import cdr_ctrl_pkg::*;
#(
    parameter int  WIN = WIN_DEF,
    localparam int AW  = cw(WIN) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          acc,
    input  logic          up,
    input  logic          down,
    output logic          win_end,
    output logic [AW-1:0] abs_net
);

    localparam int CW = cw(WIN);
    localparam int NW = AW + 1;

    logic        [CW-1:0] cnt_q;
    logic signed [NW-1:0] net_q, net_d;

    always_comb begin
        net_d = net_q;
        if (up && !down)      net_d = net_q + NW'(1);
        else if (down && !up) net_d = net_q - NW'(1);
        abs_net = net_d[NW-1] ? AW'(-net_d) : AW'(net_d);
        win_end = acc && (cnt_q == CW'(WIN - 1));
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
            net_q <= '0;
        end else if (acc) begin
            // The evaluating vote is consumed by the window that ends with it.
            if (win_end) begin
                cnt_q <= '0;
                net_q <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
                net_q <= net_d;
            end
        end
    end

endmodule

// File: rtl/cdr_lock_ctrl.sv
// CDR lock controller: steps the phase-interpolator code from phase-detector votes and
// walks SETTLE -> ACQ -> TRACK -> LOCK based on per-window net vote balance.
module cdr_lock_ctrl
    import cdr_ctrl_pkg::*;
#(
    parameter int SETTLE_CYC = SETTLE_CYC_DEF,
    parameter int WIN        = WIN_DEF,
    parameter int FAST_STEP  = FAST_STEP_DEF,
    parameter int ACQ_TH     = ACQ_TH_DEF,
    parameter int LOCK_TH    = LOCK_TH_DEF,
    parameter int UNLOCK_TH  = UNLOCK_TH_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vote_vld,
    input  logic       up,
    input  logic       down,
    input  logic       freeze,
    input  logic       ovr_en,
    input  logic [5:0] ovr_code,
    output logic [5:0] vs,
    output logic       locked,
    output logic       lock_lost,
    output logic [1:0] state
);

    localparam int SW = cw(SETTLE_CYC);
    localparam int AW = cw(WIN) + 1;

    cdr_state_e    state_q, state_d;
    logic [SW-1:0] settle_q, settle_d;
    logic [5:0]    vs_q, vs_d;
    logic          locked_q, locked_d;
    logic          lost_q, lost_d;
    logic          acc, win_end;
    logic [AW-1:0] abs_net;
    logic [5:0]    step;

    assign acc = vote_vld && !freeze && !ovr_en && (state_q != ST_SETTLE);

    cdr_win_acc #(.WIN(WIN)) u_win_acc (
        .clk     (clk),
        .rst     (rst),
        .clr     (ovr_en),
        .acc     (acc),
        .up      (up),
        .down    (down),
        .win_end (win_end),
        .abs_net (abs_net)
    );

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        vs_d     = vs_q;
        locked_d = locked_q;
        lost_d   = 1'b0;
        // Step follows the state the vote arrived in, even if that vote moves the FSM.
        step     = (state_q == ST_ACQ) ? 6'(FAST_STEP) : 6'd1;

        if (ovr_en) begin
            state_d  = ST_SETTLE;
            settle_d = '0;
            vs_d     = ovr_code;
            locked_d = 1'b0;
        end else if (!freeze) begin
            if (state_q == ST_SETTLE) begin
                if (settle_q == SW'(SETTLE_CYC - 1)) begin
                    state_d  = ST_ACQ;
                    settle_d = '0;
                end else begin
                    settle_d = settle_q + SW'(1);
                end
            end
            if (acc) begin
                if (up && !down)      vs_d = vs_q + step;
                else if (down && !up) vs_d = vs_q - step;
                if (win_end) begin
                    case (state_q)
                        ST_ACQ:   if (int'(abs_net) <= ACQ_TH) state_d = ST_TRACK;
                        ST_TRACK: if (int'(abs_net) <= LOCK_TH) begin
                            state_d  = ST_LOCK;
                            locked_d = 1'b1;
                        end
                        ST_LOCK:  if (int'(abs_net) > UNLOCK_TH) begin
                            state_d  = ST_ACQ;
                            locked_d = 1'b0;
                            lost_d   = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_SETTLE;
            settle_q <= '0;
            vs_q     <= VS_RST;
            locked_q <= 1'b0;
            lost_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            vs_q     <= vs_d;
            locked_q <= locked_d;
            lost_q   <= lost_d;
        end
    end

    assign vs        = vs_q;
    assign locked    = locked_q;
    assign lock_lost = lost_q;
    assign state     = state_q;

endmodule
